// File: rtl/ama_riscv_result_pipe_if.sv
// ama_riscv_result_pipe_if: EXE-to-WBK result, forwarding and register-file bus (master drives EXE/dcache/selects, slave returns stage state)
interface ama_riscv_result_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
);
  logic             hazard_to_exe;
  logic [RF_AW-1:0] rd_exe;
  logic             rd_we_exe;
  logic             rdp_we_exe;
  logic             load_inst_exe;
  logic             mult_inst_exe;
  logic [XLEN-1:0]  res_exe;
  logic [XLEN-1:0]  resp_exe;
  logic [XLEN-1:0]  mult_res_mem;
  logic [XLEN-1:0]  mult_resp_mem;
  logic             dc_rsp_valid;
  logic [XLEN-1:0]  dc_rsp_data;
  logic [1:0]       fwd_src_sel_rs1_dec;
  logic [1:0]       fwd_src_sel_rs2_dec;
  logic [1:0]       fwd_src_sel_rs1_exe;
  logic [1:0]       fwd_src_sel_rs2_exe;
  logic [XLEN-1:0]  fwd_data_rs1_dec;
  logic [XLEN-1:0]  fwd_data_rs2_dec;
  logic [XLEN-1:0]  fwd_data_rs1_exe;
  logic [XLEN-1:0]  fwd_data_rs2_exe;
  logic [RF_AW-1:0] rd_mem;
  logic [RF_AW-1:0] rd_wbk;
  logic             rd_we_mem;
  logic             rd_we_wbk;
  logic             rdp_we_mem;
  logic             rdp_we_wbk;
  logic             load_inst_mem;
  logic             load_inst_wbk;
  logic             mult_inst_mem;
  logic             dc_stalled;
  logic             rf_we;
  logic             rf_wep;
  logic [RF_AW-1:0] rf_addr;
  logic [RF_AW-1:0] rf_addrp;
  logic [XLEN-1:0]  rf_data;
  logic [XLEN-1:0]  rf_datap;
  modport master (
    output hazard_to_exe, rd_exe, rd_we_exe, rdp_we_exe, load_inst_exe, mult_inst_exe,
           res_exe, resp_exe, mult_res_mem, mult_resp_mem, dc_rsp_valid, dc_rsp_data,
           fwd_src_sel_rs1_dec, fwd_src_sel_rs2_dec, fwd_src_sel_rs1_exe, fwd_src_sel_rs2_exe,
    input  fwd_data_rs1_dec, fwd_data_rs2_dec, fwd_data_rs1_exe, fwd_data_rs2_exe,
           rd_mem, rd_wbk, rd_we_mem, rd_we_wbk, rdp_we_mem, rdp_we_wbk,
           load_inst_mem, load_inst_wbk, mult_inst_mem, dc_stalled,
           rf_we, rf_wep, rf_addr, rf_addrp, rf_data, rf_datap
  );
  modport slave (
    input  hazard_to_exe, rd_exe, rd_we_exe, rdp_we_exe, load_inst_exe, mult_inst_exe,
           res_exe, resp_exe, mult_res_mem, mult_resp_mem, dc_rsp_valid, dc_rsp_data,
           fwd_src_sel_rs1_dec, fwd_src_sel_rs2_dec, fwd_src_sel_rs1_exe, fwd_src_sel_rs2_exe,
    output fwd_data_rs1_dec, fwd_data_rs2_dec, fwd_data_rs1_exe, fwd_data_rs2_exe,
           rd_mem, rd_wbk, rd_we_mem, rd_we_wbk, rdp_we_mem, rdp_we_wbk,
           load_inst_mem, load_inst_wbk, mult_inst_mem, dc_stalled,
           rf_we, rf_wep, rf_addr, rf_addrp, rf_data, rf_datap
  );
endinterface

// File: rtl/ama_riscv_result_pipe.sv
// ama_riscv_result_pipe: carries EXE results through MEM/WBK, forwards them to DEC/EXE and drives RF writes (clk, rst, bus slave)
module ama_riscv_result_pipe #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input logic                   clk,
  input logic                   rst,
  ama_riscv_result_pipe_if.slave bus
);
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic             we;
    logic             wep;
    logic             ld;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  resp;
  } stage_t;
  stage_t mem_q, mem_d, wbk_q, wbk_d, exe;
  logic mul_mem_q, mul_mem_d, stall;
  logic [XLEN-1:0] mem_rd_v, mem_rdp_v, wbk_rd_v;
  function automatic logic [XLEN-1:0] fwd(input logic [1:0] s, input logic [XLEN-1:0] m, w, mp, wp);
    return s[1] ? (s[0] ? wp : mp) : (s[0] ? w : m);
  endfunction
  assign stall     = wbk_q.ld && !bus.dc_rsp_valid;
  assign mem_rd_v  = mul_mem_q ? bus.mult_res_mem : mem_q.res;
  assign mem_rdp_v = mul_mem_q ? bus.mult_resp_mem : mem_q.resp;
  assign wbk_rd_v  = wbk_q.ld ? bus.dc_rsp_data : wbk_q.res;
  always_comb begin
    exe = '{rd: bus.rd_exe, we: bus.rd_we_exe, wep: bus.rdp_we_exe && !bus.rd_exe[0],
            ld: bus.load_inst_exe, res: bus.res_exe, resp: bus.resp_exe};
    mem_d     = stall ? mem_q : bus.hazard_to_exe ? '0 : exe;
    mul_mem_d = stall ? mul_mem_q : !bus.hazard_to_exe && bus.mult_inst_exe;
    wbk_d     = stall ? wbk_q : '{rd: mem_q.rd, we: mem_q.we, wep: mem_q.wep, ld: mem_q.ld,
                                  res: mem_rd_v, resp: mem_rdp_v};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '0;
      wbk_q     <= '0;
      mul_mem_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wbk_q     <= wbk_d;
      mul_mem_q <= mul_mem_d;
    end
  end
  assign bus.rd_mem        = mem_q.rd;
  assign bus.rd_we_mem     = mem_q.we;
  assign bus.rdp_we_mem    = mem_q.wep;
  assign bus.load_inst_mem = mem_q.ld;
  assign bus.mult_inst_mem = mul_mem_q;
  assign bus.rd_wbk        = wbk_q.rd;
  assign bus.rd_we_wbk     = wbk_q.we;
  assign bus.rdp_we_wbk    = wbk_q.wep;
  assign bus.load_inst_wbk = wbk_q.ld;
  assign bus.dc_stalled    = stall;
  assign bus.fwd_data_rs1_dec = fwd(bus.fwd_src_sel_rs1_dec, mem_rd_v, wbk_rd_v, mem_rdp_v, wbk_q.resp);
  assign bus.fwd_data_rs2_dec = fwd(bus.fwd_src_sel_rs2_dec, mem_rd_v, wbk_rd_v, mem_rdp_v, wbk_q.resp);
  assign bus.fwd_data_rs1_exe = fwd(bus.fwd_src_sel_rs1_exe, mem_rd_v, wbk_rd_v, mem_rdp_v, wbk_q.resp);
  assign bus.fwd_data_rs2_exe = fwd(bus.fwd_src_sel_rs2_exe, mem_rd_v, wbk_rd_v, mem_rdp_v, wbk_q.resp);
  assign bus.rf_we    = wbk_q.we && (wbk_q.rd != '0) && !stall;
  assign bus.rf_wep   = wbk_q.wep && !stall;
  assign bus.rf_addr  = wbk_q.rd;
  assign bus.rf_addrp = {wbk_q.rd[RF_AW-1:1], 1'b1};
  assign bus.rf_data  = wbk_rd_v;
  assign bus.rf_datap = wbk_q.resp;
endmodule

// File: tb/tb_ama_riscv_result_pipe.sv
// tb_ama_riscv_result_pipe: directed scenarios plus randomized run against a transaction-level model
module tb_ama_riscv_result_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ama_riscv_result_pipe_if bus ();
  ama_riscv_result_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [4:0]  rd;
    logic        we, wep, ld, mul;
    logic [31:0] res, resp;
  } rec_t;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.hazard_to_exe = 0; bus.rd_exe = 0; bus.rd_we_exe = 0; bus.rdp_we_exe = 0;
    bus.load_inst_exe = 0; bus.mult_inst_exe = 0; bus.res_exe = 0; bus.resp_exe = 0;
    bus.mult_res_mem = 0; bus.mult_resp_mem = 0; bus.dc_rsp_valid = 0; bus.dc_rsp_data = 0;
    bus.fwd_src_sel_rs1_dec = 0; bus.fwd_src_sel_rs2_dec = 0;
    bus.fwd_src_sel_rs1_exe = 0; bus.fwd_src_sel_rs2_exe = 0;
  endtask
  task automatic set_exe(input logic [4:0] rd, input logic we, wep, ld, mul, input logic [31:0] res, resp);
    bus.rd_exe = rd; bus.rd_we_exe = we; bus.rdp_we_exe = wep; bus.load_inst_exe = ld;
    bus.mult_inst_exe = mul; bus.res_exe = res; bus.resp_exe = resp;
  endtask
  task automatic do_reset;
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask
  task automatic test_reset;
    rst = 1; idle(); tick(); tick();
    checks++; if (bus.rd_we_mem !== 0 || bus.rd_mem !== 0 || bus.load_inst_mem !== 0 || bus.mult_inst_mem !== 0 || bus.rdp_we_mem !== 0) begin errors++; $display("FAIL reset_mem: we=%b rd=%0d ld=%b mul=%b wep=%b, want all 0", bus.rd_we_mem, bus.rd_mem, bus.load_inst_mem, bus.mult_inst_mem, bus.rdp_we_mem); end
    checks++; if (bus.rd_we_wbk !== 0 || bus.rd_wbk !== 0 || bus.load_inst_wbk !== 0 || bus.rdp_we_wbk !== 0 || bus.dc_stalled !== 0) begin errors++; $display("FAIL reset_wbk: we=%b rd=%0d ld=%b wep=%b stall=%b, want all 0", bus.rd_we_wbk, bus.rd_wbk, bus.load_inst_wbk, bus.rdp_we_wbk, bus.dc_stalled); end
    checks++; if (bus.rf_we !== 0 || bus.rf_wep !== 0 || bus.rf_data !== 0 || bus.fwd_data_rs1_dec !== 0) begin errors++; $display("FAIL reset_rf: we=%b wep=%b data=%h fwd=%h, want 0", bus.rf_we, bus.rf_wep, bus.rf_data, bus.fwd_data_rs1_dec); end
    rst = 0;
  endtask
  task automatic test_alu;
    do_reset();
    set_exe(5, 1, 0, 0, 0, 32'h11, 0); tick(); idle();
    checks++; if (bus.rd_mem !== 5 || bus.rd_we_mem !== 1) begin errors++; $display("FAIL alu_mem: rd=%0d we=%b, want 5 1", bus.rd_mem, bus.rd_we_mem); end
    tick();
    checks++; if (bus.rf_we !== 1 || bus.rf_addr !== 5 || bus.rf_data !== 32'h11) begin errors++; $display("FAIL alu_wbk: we=%b addr=%0d data=%h, want 1 5 11", bus.rf_we, bus.rf_addr, bus.rf_data); end
  endtask
  task automatic test_pair;
    do_reset();
    set_exe(6, 1, 1, 0, 0, 32'hA, 32'hB); tick(); idle();
    bus.fwd_src_sel_rs1_dec = 2'b00; bus.fwd_src_sel_rs2_dec = 2'b10;
    bus.fwd_src_sel_rs1_exe = 2'b00; bus.fwd_src_sel_rs2_exe = 2'b10; #1;
    checks++; if (bus.fwd_data_rs1_dec !== 32'hA || bus.fwd_data_rs2_dec !== 32'hB) begin errors++; $display("FAIL pair_mem_dec: %h %h, want a b", bus.fwd_data_rs1_dec, bus.fwd_data_rs2_dec); end
    checks++; if (bus.fwd_data_rs1_exe !== 32'hA || bus.fwd_data_rs2_exe !== 32'hB) begin errors++; $display("FAIL pair_mem_exe: %h %h, want a b", bus.fwd_data_rs1_exe, bus.fwd_data_rs2_exe); end
    tick();
    bus.fwd_src_sel_rs1_dec = 2'b01; bus.fwd_src_sel_rs2_dec = 2'b11;
    bus.fwd_src_sel_rs1_exe = 2'b11; bus.fwd_src_sel_rs2_exe = 2'b01; #1;
    checks++; if (bus.fwd_data_rs1_dec !== 32'hA || bus.fwd_data_rs2_dec !== 32'hB || bus.fwd_data_rs1_exe !== 32'hB || bus.fwd_data_rs2_exe !== 32'hA) begin errors++; $display("FAIL pair_wbk_fwd: %h %h %h %h, want a b b a", bus.fwd_data_rs1_dec, bus.fwd_data_rs2_dec, bus.fwd_data_rs1_exe, bus.fwd_data_rs2_exe); end
    checks++; if (bus.rf_wep !== 1 || bus.rf_addrp !== 7 || bus.rf_datap !== 32'hB || bus.rf_addr !== 6) begin errors++; $display("FAIL pair_rf: wep=%b addrp=%0d datap=%h addr=%0d, want 1 7 b 6", bus.rf_wep, bus.rf_addrp, bus.rf_datap, bus.rf_addr); end
    idle();
  endtask
  task automatic test_load_stall;
    do_reset();
    set_exe(8, 1, 0, 1, 0, 0, 0); tick();
    set_exe(9, 1, 0, 0, 0, 32'h99, 0); tick();
    set_exe(10, 1, 0, 0, 0, 32'h77, 0);
    for (int i = 0; i < 3; i++) begin
      bus.hazard_to_exe = (i == 1); #1;
      checks++; if (bus.dc_stalled !== 1 || bus.rd_wbk !== 8 || bus.rd_mem !== 9 || bus.rd_we_mem !== 1 || bus.rf_we !== 0) begin errors++; $display("FAIL load_stall%0d: stall=%b rd_wbk=%0d rd_mem=%0d we_mem=%b rf_we=%b, want 1 8 9 1 0", i, bus.dc_stalled, bus.rd_wbk, bus.rd_mem, bus.rd_we_mem, bus.rf_we); end
      tick();
    end
    bus.hazard_to_exe = 0; bus.dc_rsp_valid = 1; bus.dc_rsp_data = 32'hDEAD; #1;
    checks++; if (bus.dc_stalled !== 0 || bus.rf_we !== 1 || bus.rf_addr !== 8 || bus.rf_data !== 32'hDEAD) begin errors++; $display("FAIL load_done: stall=%b we=%b addr=%0d data=%h, want 0 1 8 dead", bus.dc_stalled, bus.rf_we, bus.rf_addr, bus.rf_data); end
    tick(); idle();
    checks++; if (bus.rd_wbk !== 9 || bus.rd_mem !== 10 || bus.load_inst_wbk !== 0) begin errors++; $display("FAIL load_adv: rd_wbk=%0d rd_mem=%0d ld=%b, want 9 10 0", bus.rd_wbk, bus.rd_mem, bus.load_inst_wbk); end
  endtask
  task automatic test_mult_hazard;
    do_reset();
    set_exe(12, 1, 0, 0, 1, 32'h5, 0); tick();
    set_exe(13, 1, 0, 0, 0, 32'h3, 0);
    bus.mult_res_mem = 32'h1234; bus.hazard_to_exe = 1; #1;
    checks++; if (bus.mult_inst_mem !== 1 || bus.fwd_data_rs1_dec !== 32'h1234) begin errors++; $display("FAIL mult_mem: mul=%b fwd=%h, want 1 1234", bus.mult_inst_mem, bus.fwd_data_rs1_dec); end
    tick(); idle();
    checks++; if (bus.rd_we_mem !== 0 || bus.rd_mem !== 0 || bus.mult_inst_mem !== 0) begin errors++; $display("FAIL mult_bubble: we=%b rd=%0d mul=%b, want 0 0 0", bus.rd_we_mem, bus.rd_mem, bus.mult_inst_mem); end
    checks++; if (bus.rd_wbk !== 12 || bus.rf_we !== 1 || bus.rf_data !== 32'h1234) begin errors++; $display("FAIL mult_wbk: rd=%0d we=%b data=%h, want 12 1 1234", bus.rd_wbk, bus.rf_we, bus.rf_data); end
  endtask
  task automatic test_x0;
    do_reset();
    set_exe(0, 1, 0, 0, 0, 32'h55, 0); tick(); idle();
    checks++; if (bus.rd_we_mem !== 1) begin errors++; $display("FAIL x0_mem: we=%b, want 1", bus.rd_we_mem); end
    tick();
    checks++; if (bus.rd_we_wbk !== 1 || bus.rf_we !== 0) begin errors++; $display("FAIL x0_wbk: we_wbk=%b rf_we=%b, want 1 0", bus.rd_we_wbk, bus.rf_we); end
  endtask
  task automatic test_rst_stall;
    do_reset();
    set_exe(8, 1, 0, 1, 0, 0, 0); tick();
    set_exe(3, 1, 1, 0, 0, 1, 2); tick();
    checks++; if (bus.dc_stalled !== 1) begin errors++; $display("FAIL rst_stall_pre: stall=%b, want 1", bus.dc_stalled); end
    rst = 1; bus.dc_rsp_valid = 1; bus.dc_rsp_data = 32'hBEEF; tick();
    rst = 0; idle(); #1;
    checks++; if (bus.load_inst_wbk !== 0 || bus.dc_stalled !== 0 || bus.rd_we_wbk !== 0 || bus.rd_we_mem !== 0 || bus.rf_we !== 0 || bus.rf_wep !== 0) begin errors++; $display("FAIL rst_stall: ld=%b stall=%b we_wbk=%b we_mem=%b rf_we=%b rf_wep=%b, want all 0", bus.load_inst_wbk, bus.dc_stalled, bus.rd_we_wbk, bus.rd_we_mem, bus.rf_we, bus.rf_wep); end
  endtask
  task automatic test_random;
    rec_t m, w, x, z;
    logic [31:0] v[4];
    logic stl, rfw, hz, r;
    z = '{rd: 0, we: 0, wep: 0, ld: 0, mul: 0, res: 0, resp: 0};
    do_reset();
    m = z; w = z;
    for (int n = 0; n < 600; n++) begin
      x = '{rd: 5'($urandom_range(0, 31)), we: 1'($urandom_range(0, 1)), wep: 1'($urandom_range(0, 1)),
            ld: ($urandom_range(0, 3) == 0), mul: ($urandom_range(0, 4) == 0), res: $urandom, resp: $urandom};
      hz = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 49) == 0);
      set_exe(x.rd, x.we, x.wep, x.ld, x.mul, x.res, x.resp);
      bus.hazard_to_exe = hz; bus.mult_res_mem = $urandom; bus.mult_resp_mem = $urandom;
      bus.dc_rsp_valid = 1'($urandom_range(0, 1)); bus.dc_rsp_data = $urandom;
      bus.fwd_src_sel_rs1_dec = 2'($urandom); bus.fwd_src_sel_rs2_dec = 2'($urandom);
      bus.fwd_src_sel_rs1_exe = 2'($urandom); bus.fwd_src_sel_rs2_exe = 2'($urandom);
      rst = r; #1;
      v[0] = m.mul ? bus.mult_res_mem : m.res;
      v[1] = w.ld ? bus.dc_rsp_data : w.res;
      v[2] = m.mul ? bus.mult_resp_mem : m.resp;
      v[3] = w.resp;
      stl = w.ld && !bus.dc_rsp_valid;
      rfw = w.we && w.rd != 0 && !stl;
      checks++; if ({bus.rd_mem, bus.rd_we_mem, bus.rdp_we_mem, bus.load_inst_mem, bus.mult_inst_mem} !== {m.rd, m.we, m.wep, m.ld, m.mul}) begin errors++; $display("FAIL rnd_mem[%0d]: rd=%0d we=%b wep=%b ld=%b mul=%b, want %0d %b %b %b %b", n, bus.rd_mem, bus.rd_we_mem, bus.rdp_we_mem, bus.load_inst_mem, bus.mult_inst_mem, m.rd, m.we, m.wep, m.ld, m.mul); end
      checks++; if ({bus.rd_wbk, bus.rd_we_wbk, bus.rdp_we_wbk, bus.load_inst_wbk, bus.dc_stalled} !== {w.rd, w.we, w.wep, w.ld, stl}) begin errors++; $display("FAIL rnd_wbk[%0d]: rd=%0d we=%b wep=%b ld=%b stall=%b, want %0d %b %b %b %b", n, bus.rd_wbk, bus.rd_we_wbk, bus.rdp_we_wbk, bus.load_inst_wbk, bus.dc_stalled, w.rd, w.we, w.wep, w.ld, stl); end
      checks++; if (bus.rf_we !== rfw || bus.rf_wep !== (w.wep && !stl)) begin errors++; $display("FAIL rnd_rfwe[%0d]: we=%b wep=%b, want %b %b", n, bus.rf_we, bus.rf_wep, rfw, w.wep && !stl); end
      if (rfw) begin
        checks++; if (bus.rf_addr !== w.rd || bus.rf_data !== v[1]) begin errors++; $display("FAIL rnd_rf[%0d]: addr=%0d data=%h, want %0d %h", n, bus.rf_addr, bus.rf_data, w.rd, v[1]); end
      end
      if (w.wep && !stl) begin
        checks++; if (bus.rf_addrp !== (w.rd | 5'd1) || bus.rf_datap !== w.resp) begin errors++; $display("FAIL rnd_rfp[%0d]: addr=%0d data=%h, want %0d %h", n, bus.rf_addrp, bus.rf_datap, w.rd | 5'd1, w.resp); end
      end
      if (m.we && w.we) begin
        checks++; if (bus.fwd_data_rs1_dec !== v[bus.fwd_src_sel_rs1_dec] || bus.fwd_data_rs1_exe !== v[bus.fwd_src_sel_rs1_exe]) begin errors++; $display("FAIL rnd_fwd1[%0d]: dec=%h exe=%h, want %h %h", n, bus.fwd_data_rs1_dec, bus.fwd_data_rs1_exe, v[bus.fwd_src_sel_rs1_dec], v[bus.fwd_src_sel_rs1_exe]); end
        checks++; if (bus.fwd_data_rs2_dec !== v[bus.fwd_src_sel_rs2_dec] || bus.fwd_data_rs2_exe !== v[bus.fwd_src_sel_rs2_exe]) begin errors++; $display("FAIL rnd_fwd2[%0d]: dec=%h exe=%h, want %h %h", n, bus.fwd_data_rs2_dec, bus.fwd_data_rs2_exe, v[bus.fwd_src_sel_rs2_dec], v[bus.fwd_src_sel_rs2_exe]); end
      end
      tick();
      if (r) begin
        m = z; w = z;
      end else if (!stl) begin
        w = m; w.mul = 0; w.res = v[0]; w.resp = v[2];
        if (hz) m = z;
        else begin
          m = x; m.wep = x.wep && !x.rd[0];
        end
      end
    end
    rst = 0; idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_alu();
    test_pair();
    test_load_stall();
    test_mult_hazard();
    test_x0();
    test_rst_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
